// File: rtl/plc_sequencer.sv
// PLC instruction sequencer: fetch/decode/exec over a synchronous ROM.
// Drives an external combinational ALU and owns acc, r0..r3 and pc.
module plc_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  output logic [4:0]      alu_op,
  output logic [7:0]      alu_in0,
  output logic [7:0]      alu_in1,
  input  logic [7:0]      alu_out,
  output logic [7:0]      acc,
  output logic            zero,
  output logic            instr_done,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  // Opcodes whose ALU result is written back to acc
  localparam logic [15:0] ALU_MASK = 16'h27BF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, tgt;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      r_q [4];
  logic [7:0]      r_d [4];
  logic [4:0]      op;
  logic            is_alu, is_st, is_jmp;
  logic            is_jz, is_jnz, is_halt;

  assign op      = ir_q[15:11];
  assign is_alu  = !op[4] && ALU_MASK[op[3:0]];
  assign is_st   = (op == 5'd16);
  assign is_jmp  = (op == 5'd17);
  assign is_jz   = (op == 5'd18);
  assign is_jnz  = (op == 5'd19);
  assign is_halt = (op == 5'd31);
  assign pc_inc  = pc_q + PC_W'(1);
  assign tgt     = ir_q[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (en) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_halt ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
    endcase
  end

  always_comb begin
    instr_done = (state_q == S_EXEC);
    halted     = (state_q == S_HALT);
  end

  always_comb begin
    pc_d  = pc_q;
    acc_d = acc_q;
    ir_d  = ir_q;
    r_d   = r_q;
    if (state_q == S_DECODE) ir_d = prog_data;
    if (state_q == S_EXEC) begin
      pc_d = pc_inc;
      unique case (1'b1)
        is_alu:  acc_d = alu_out;
        is_st:   r_d[ir_q[9:8]] = acc_q;
        is_jmp:  pc_d = tgt;
        is_jz:   if (acc_q == 8'd0) pc_d = tgt;
        is_jnz:  if (acc_q != 8'd0) pc_d = tgt;
        is_halt: pc_d = pc_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= '0;
      acc_q <= '0;
      ir_q  <= '0;
      r_q   <= '{default: '0};
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
      ir_q  <= ir_d;
      r_q   <= r_d;
    end
  end

  assign prog_addr = pc_q;
  assign alu_op    = op;
  assign alu_in0   = acc_q;
  assign alu_in1   = ir_q[10] ? ir_q[7:0] : r_q[ir_q[9:8]];
  assign acc       = acc_q;
  assign zero      = (acc_q == 8'd0);

endmodule
